// File: rtl/cmul_result_buffer_pkg.sv
// Shared types and constants for the complex-multiplier result buffer.
// Package cmul_pkg: component width, multiplier latency, complex sample type, clog2 helper.
package cmul_pkg;

  localparam int DATA_W       = 32;
  localparam int CMUL_LATENCY = 7;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_result_buffer_if.sv
// Bus bundle between issuer/multiplier/consumer and the result buffer.
// Optional statistics signals exist only when CMUL_RB_STATS_EN is defined.
interface cmul_result_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = cmul_pkg::DATA_W
);

  logic                   issue;
  logic                   can_issue;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_real;
  logic [DATA_W-1:0]      in_imag;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_real;
  logic [DATA_W-1:0]      out_imag;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   protocol_err;
`ifdef CMUL_RB_STATS_EN
  logic [31:0]            push_cnt;
  logic [31:0]            pop_cnt;
  logic [$clog2(DEPTH):0] max_count;
`endif

  modport master (
    output issue, in_valid, in_real, in_imag, out_ready,
    input  can_issue, out_valid, out_real, out_imag, count, overflow,
`ifdef CMUL_RB_STATS_EN
    input  push_cnt, pop_cnt, max_count,
`endif
    input  protocol_err
  );

  modport slave (
    input  issue, in_valid, in_real, in_imag, out_ready,
    output can_issue, out_valid, out_real, out_imag, count, overflow,
`ifdef CMUL_RB_STATS_EN
    output push_cnt, pop_cnt, max_count,
`endif
    output protocol_err
  );

endinterface

// File: rtl/cmul_rb_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; gates push/pop against full/empty itself.
// Reports accepted push, accepted pop and dropped push so the top can keep credits and flags.
module cmul_rb_fifo
  import cmul_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  cplx_t                i_data,
  input  logic                 i_pop,
  output cplx_t                o_data,
  output logic                 o_empty,
  output logic                 o_push_ok,
  output logic                 o_pop_ok,
  output logic                 o_drop,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  cplx_t       r_mem [DEPTH];
  logic        w_full;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;

  assign o_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot being written, so full-with-pop still accepts.
  assign o_push_ok = i_push & (~w_full | o_pop_ok);
  assign o_drop    = i_push & w_full & ~o_pop_ok;

  // Zero when empty so the outputs show a defined value out of reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (o_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (o_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cmul_result_buffer.sv
// Credit-managed result buffer behind the complex multiplier: issue credits, sticky flags, FIFO.
// Define CMUL_RB_STATS_EN to add push/pop counters and the occupancy high-water mark.
module cmul_result_buffer
  import cmul_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = CMUL_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  cmul_result_buffer_if.slave  bus
);

  localparam int CW = clog2(DEPTH) + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < LATENCY + 1)) begin : g_bad_depth
    $error("cmul_result_buffer: DEPTH must be a power of two and at least LATENCY+1");
  end

  logic [CW-1:0] r_credits;
  logic          r_overflow;
  logic          r_protocol_err;

  logic          w_can_issue;
  logic          w_accept;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_drop;
  logic [CW-1:0] w_count;
  cplx_t         w_in_data;
  cplx_t         w_out_data;

  assign w_in_data   = {bus.in_real, bus.in_imag};
  assign w_can_issue = (r_credits != '0);
  assign w_accept    = bus.issue & w_can_issue;

  cmul_rb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (bus.in_valid),
    .i_data    (w_in_data),
    .i_pop     (bus.out_ready),
    .o_data    (w_out_data),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok),
    .o_drop    (w_drop),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits      <= CW'(DEPTH);
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      case ({w_accept, w_pop_ok})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
      if (w_drop)                    r_overflow     <= 1'b1;
      if (bus.issue && !w_can_issue) r_protocol_err <= 1'b1;
    end
  end

  assign bus.can_issue    = w_can_issue;
  assign bus.out_valid    = ~w_empty;
  assign bus.out_real     = w_out_data.re;
  assign bus.out_imag     = w_out_data.im;
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.protocol_err = r_protocol_err;

`ifdef CMUL_RB_STATS_EN
  logic [31:0]   r_push_cnt;
  logic [31:0]   r_pop_cnt;
  logic [CW-1:0] r_max_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_cnt  <= '0;
      r_pop_cnt   <= '0;
      r_max_count <= '0;
    end else begin
      if (w_push_ok)               r_push_cnt  <= r_push_cnt + 1'b1;
      if (w_pop_ok)                r_pop_cnt   <= r_pop_cnt + 1'b1;
      if (w_count > r_max_count)   r_max_count <= w_count;
    end
  end

  assign bus.push_cnt  = r_push_cnt;
  assign bus.pop_cnt   = r_pop_cnt;
  assign bus.max_count = r_max_count;
`endif

endmodule

// File: tb/tb_cmul_result_buffer.sv
// Bench for cmul_result_buffer: directed vectors, a queue-based reference model checked every
// cycle, and literal expectations; a 7-stage delay line stands in for the multiplier.
module tb_cmul_result_buffer;
  import cmul_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = CMUL_LATENCY;

  logic clk;
  logic rst;

  cmul_result_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  cmul_result_buffer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // multiplier stand-in plus a direct injection path for fault-style pushes
  logic        pipe_v;
  logic [63:0] pipe_d;
  logic        inj_v;
  logic [63:0] inj_d;
  logic [LAT-1:0] pv;
  logic [63:0]    pd [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], pipe_v};
      pd[0] <= pipe_d;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign bus.in_valid = pv[LAT-1] | inj_v;
  assign bus.in_real  = inj_v ? inj_d[63:32] : pd[LAT-1][63:32];
  assign bus.in_imag  = inj_v ? inj_d[31:0]  : pd[LAT-1][31:0];

  // reference model
  logic [63:0] mq [$];
  int          m_cred;
  bit          m_ovf, m_perr, m_pop;
  int          m_pushes, m_pops, m_max, sz0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cred = DEPTH; m_ovf = 0; m_perr = 0;
      m_pushes = 0; m_pops = 0; m_max = 0;
    end else begin
      sz0   = mq.size();
      m_pop = (sz0 != 0) && bus.out_ready;
      if (bus.issue && m_cred == 0) m_perr = 1;
      if (bus.issue && m_cred != 0) m_cred--;
      if (m_pop) begin
        m_cred++;
        void'(mq.pop_front());
        m_pops++;
      end
      if (bus.in_valid) begin
        if (sz0 < DEPTH || m_pop) begin
          mq.push_back({bus.in_real, bus.in_imag});
          m_pushes++;
        end else m_ovf = 1;
      end
      if (sz0 > m_max) m_max = sz0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_can_issue", bus.can_issue, m_cred != 0);
      chk("m_out_valid", bus.out_valid, mq.size() != 0);
      chk("m_count", bus.count, mq.size());
      chk("m_overflow", bus.overflow, m_ovf);
      chk("m_protocol_err", bus.protocol_err, m_perr);
      if (mq.size() != 0) chk("m_out_data", {bus.out_real, bus.out_imag}, mq[0]);
      else                chk("m_out_zero", {bus.out_real, bus.out_imag}, 64'd0);
`ifdef CMUL_RB_STATS_EN
      chk("m_push_cnt", bus.push_cnt, m_pushes);
      chk("m_pop_cnt", bus.pop_cnt, m_pops);
      chk("m_max_count", bus.max_count, m_max);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [63:0] d);
    bus.issue = 1'b1; pipe_v = 1'b1; pipe_d = d;
    tick();
    bus.issue = 1'b0; pipe_v = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, bus.out_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int issued;
    int cyc;
    rst = 1'b1;
    bus.issue = 1'b0; bus.out_ready = 1'b0;
    pipe_v = 1'b0; pipe_d = '0; inj_v = 1'b0; inj_d = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_can_issue", bus.can_issue, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_out_data", {bus.out_real, bus.out_imag}, 64'd0);
    chk("rst_flags", {bus.overflow, bus.protocol_err}, 2'b00);

    // pass-through and latency
    do_issue({32'h3F800000, 32'h00000000});
    wait_valid("pt_timeout", n);
    chk("pt_latency", n, LAT);
    chk("pt_out_real", bus.out_real, 32'h3F800000);
    chk("pt_out_imag", bus.out_imag, 32'h00000000);
    chk("pt_count", bus.count, 1);
    pop_one();
    chk("pt_count_after_pop", bus.count, 0);
    chk("pt_can_issue", bus.can_issue, 1'b1);

    // ordering
    do_issue({32'hC0E00000, 32'h41B00000});
    do_issue({32'hC0A00000, 32'h41200000});
    wait_valid("ord_timeout", n);
    chk("ord_first", {bus.out_real, bus.out_imag}, {32'hC0E00000, 32'h41B00000});
    pop_one();
    chk("ord_second", {bus.out_real, bus.out_imag}, {32'hC0A00000, 32'h41200000});
    pop_one();
    chk("ord_empty", bus.count, 0);

    // credit exhaustion
    for (int i = 0; i < DEPTH; i++) begin
      chk("cr_can_issue_before", bus.can_issue, 1'b1);
      do_issue({32'h40000000 + i, 32'(i)});
    end
    chk("cr_can_issue_zero", bus.can_issue, 1'b0);
    repeat (LAT + 2) tick();
    chk("cr_count_full", bus.count, DEPTH);
    chk("cr_no_overflow", bus.overflow, 1'b0);
    bus.issue = 1'b1;
    tick();
    bus.issue = 1'b0;
    chk("cr_protocol_err", bus.protocol_err, 1'b1);
    repeat (LAT + 1) tick();
    chk("cr_count_held", bus.count, DEPTH);

    // full boundary: push with pop, then push without pop
    inj_v = 1'b1; inj_d = {32'h12345678, 32'h9ABCDEF0}; bus.out_ready = 1'b1;
    tick();
    inj_v = 1'b0; bus.out_ready = 1'b0;
    chk("fb_count_pushpop", bus.count, DEPTH);
    chk("fb_no_overflow", bus.overflow, 1'b0);
    inj_v = 1'b1; inj_d = {32'hDEADBEEF, 32'h0BADF00D};
    tick();
    inj_v = 1'b0;
    chk("fb_overflow", bus.overflow, 1'b1);
    chk("fb_count_drop", bus.count, DEPTH);
    repeat (3) tick();
    chk("fb_overflow_sticky", bus.overflow, 1'b1);

    // drain to 5 then asynchronous reset between edges
    bus.out_ready = 1'b1;
    repeat (DEPTH - 5) tick();
    bus.out_ready = 1'b0;
    chk("ar_count5", bus.count, 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_out_valid", bus.out_valid, 1'b0);
    chk("ar_can_issue", bus.can_issue, 1'b1);
    chk("ar_flags", {bus.overflow, bus.protocol_err}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // streaming with 50% consumer
    issued = 0;
    cyc = 0;
    while ((issued < 100 || bus.count != 0 || pv != '0) && cyc < 3000) begin
      bus.issue     = (issued < 100) && bus.can_issue;
      pipe_v        = bus.issue;
      pipe_d        = {32'h3F000000 + issued, 32'hBF000000 - issued};
      bus.out_ready = cyc[0];
      tick();
      if (pipe_v) issued++;
      cyc++;
    end
    bus.issue = 1'b0; pipe_v = 1'b0; bus.out_ready = 1'b0;
    chk("st_done", cyc < 3000, 1'b1);
    chk("st_issued", issued, 100);
    chk("st_count", bus.count, 0);
    chk("st_can_issue", bus.can_issue, 1'b1);
    chk("st_flags", {bus.overflow, bus.protocol_err}, 2'b00);
`ifdef CMUL_RB_STATS_EN
    chk("st_push_cnt", bus.push_cnt, 100);
    chk("st_pop_cnt", bus.pop_cnt, 100);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmul_result_buffer.md
# cmul_result_buffer

Credit-managed result buffer placed directly downstream of `complex_multiplier`. The multiplier has a fixed 7-cycle pipeline and no backpressure, so this block owns the flow control for it. It grants issue credits to the upstream issuer and captures every FP32 complex result into a FIFO. It then presents the results to a valid/ready consumer such as the FFT butterfly or the output writer. No arithmetic is done on the data, which passes through bit-exact.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two and at least `LATENCY`+1.
- `LATENCY`, 7: multiplier pipeline depth. Used for the depth check and for the bench only.
- `DATA_W`, 32: width of each real or imaginary component (IEEE-754 single).
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `issue`  in  1: upstream drives an operand set into the multiplier this cycle.
- `can_issue`  out  1: a credit is available and `issue` is permitted.
- `in_valid`  in  1: multiplier `valid`.
- `in_real`, `in_imag`  in  DATA_W each: multiplier result.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_real`, `out_imag`  out  DATA_W each: head entry.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `overflow`  out  1: sticky; a push was dropped.
- `protocol_err`  out  1: sticky; `issue` was asserted while `can_issue`=0.

## Operation
- **Credits**
  - The `credits` register resets to DEPTH.
  - `can_issue` = (`credits` != 0), driven from the register with no combinational path from `issue`.
  - Accepted issue (`issue` & `can_issue`): `credits` decrements.
  - Pop (`out_valid` & `out_ready`): `credits` increments.
  - Both in the same cycle: `credits` is unchanged.
  - `issue` while `can_issue`=0: credit is untouched and `protocol_err` sets.
  - Invariant: `credits` + in-flight ops + `count` = DEPTH.
- **FIFO**
  - Write and read pointers carry an extra wrap bit; pointers wrap modulo DEPTH.
  - Full means the indices are equal and the wrap bits differ.
  - Reads are show-ahead: `out_real`/`out_imag` reflect the head entry whenever `out_valid`=1.
  - `out_valid` = (`count` != 0).
- **Push**
  - On `in_valid`, {`in_real`, `in_imag`} is written when not full, or when full with a simultaneous pop.
  - When full with no pop, the data is dropped and `overflow` sets.
- **Pop**
  - `out_valid` & `out_ready` advances the read pointer.
  - `out_ready` while empty has no effect.
- **Ordering**: strictly FIFO, matching multiplier issue order.
- **Sticky flags** clear only on `rst`.

## Timing
- **Reset values**: `can_issue`=1, `out_valid`=0, `out_real`/`out_imag`=0, `count`=0, `overflow`=0, `protocol_err`=0, pointers 0, `credits`=DEPTH.
- **Push to output**: `in_valid` at edge t makes `out_valid`=1 after edge t+1. There is no same-cycle bypass from an empty FIFO.
- **Issue to output**: issue-to-`out_valid` latency is LATENCY+1 cycles.
- **Credit update**: a pop at edge t makes `can_issue` rise after edge t when `credits` was 0.
- **Throughput**: one issue, one push and one pop per cycle are sustained indefinitely.
- **Reset mid-operation**: pointers, credits and flags return to reset values immediately. Multiplier results arriving after reset are pushed as normal data. The system resets the multiplier together with this block.

## Configuration
- `CMUL_RB_STATS_EN` defined: adds outputs
  - `push_cnt`: 32-bit, wraps.
  - `pop_cnt`: 32-bit, wraps.
  - `max_count`: high-water mark of `count`.
  - All three reset to 0.
- `CMUL_RB_STATS_EN` undefined: these ports and counters are absent. Functional behaviour is identical in both builds.

## Structure
- **Package `cmul_pkg`**:
  - `DATA_W` and `CMUL_LATENCY`=7.
  - `cplx_t`: packed struct {real, imag}.
  - Function `clog2`.
- **Sub-module `cmul_rb_fifo`**: storage, pointers, full/empty and `count`.
- **Top level**: credits, flags and stats.

## Test plan
- **Reset**: assert `rst` mid-stream with `count`=5 → `count`=0, `out_valid`=0, `can_issue`=1, flags 0, with no clock edge needed.
- **Credit exhaustion**:
  - Stimulus: 16 back-to-back issues with `out_ready`=0.
  - Required: `can_issue`=0 after the 16th issue; 16 results land with `count`=16 and `overflow`=0.
  - Then a 17th `issue` → `protocol_err`=1 and `count` stays 16.
- **Pass-through**: push (32'h3F800000, 32'h00000000) into an empty FIFO → `out_valid` next cycle with `out_real`=32'h3F800000; pop → `count`=0 and `credits` restored.
- **Order**: push (-7.0 = 32'hC0E00000, 22.0 = 32'h41B00000), then (-5.0 = 32'hC0A00000, 10.0 = 32'h41200000) → popped in that order, bit-exact.
- **Full boundary**:
  - With `count`=16, push and pop in the same cycle → accepted, `count`=16, no overflow.
  - With `count`=16, push without pop → dropped, `overflow`=1 and held until `rst`.
- **Streaming**: 100 continuous issues with `out_ready` toggling 50% → no stall beyond the credit limit, zero flags, `push_cnt`=`pop_cnt`=100 after drain when `CMUL_RB_STATS_EN` is defined.
